// File: rtl/rw_writeback_unit_pkg.sv
// rw_writeback_unit_pkg: shared SimpleRISC widths, register constants and the queued-write entry type
package rw_writeback_unit_pkg;
  localparam int REG_W = 5;
  localparam int XLEN = 32;
  localparam logic [REG_W-1:0] RA_IDX = 5'd31;
  localparam int RD_HI = 25;
  localparam int RD_LO = 21;
  typedef struct packed {
    logic [REG_W-1:0] port;
    logic [XLEN-1:0]  data;
  } wb_entry_t;
endpackage

// File: rtl/rw_writeback_unit_if.sv
// rw_writeback_unit_if: retire input from MA and register-file port B request/grant bus
//   in_*   : retiring instruction (valid/ready handshake)
//   wr_*   : pending write at FIFO head (req/gnt handshake)
//   master : the writeback unit; slave : MA stage plus port B arbiter
interface rw_writeback_unit_if;
  import rw_writeback_unit_pkg::*;
  logic             in_valid;
  logic             in_ready;
  logic [XLEN-1:0]  in_pc;
  logic [XLEN-1:0]  in_inst;
  logic [XLEN-1:0]  in_alu;
  logic [XLEN-1:0]  in_ld;
  logic             in_isWb;
  logic             in_isLd;
  logic             in_isCall;
  logic             wr_req;
  logic             wr_gnt;
  logic [REG_W-1:0] wr_port;
  logic [XLEN-1:0]  wr_data;
  modport master (
    input  in_valid, in_pc, in_inst, in_alu, in_ld, in_isWb, in_isLd, in_isCall, wr_gnt,
    output in_ready, wr_req, wr_port, wr_data
  );
  modport slave (
    output in_valid, in_pc, in_inst, in_alu, in_ld, in_isWb, in_isLd, in_isCall, wr_gnt,
    input  in_ready, wr_req, wr_port, wr_data
  );
endinterface

// File: rtl/rw_writeback_unit_fifo.sv
// rw_writeback_unit_fifo: pending-write FIFO with per-entry valid bits for the bypass search
//   push/push_entry : enqueue (ignored when full)
//   pop             : dequeue head (ignored when empty)
//   mem/vld/rd_ptr  : storage, valid bits and head pointer for the bypass search
//   cnt/full/empty  : registered occupancy and its flags
module rw_writeback_unit_fifo
  import rw_writeback_unit_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  wb_entry_t        push_entry,
  input  logic             pop,
  output wb_entry_t        mem [DEPTH],
  output logic [DEPTH-1:0] vld,
  output logic [AW-1:0]    rd_ptr,
  output logic [CW-1:0]    cnt,
  output logic             full,
  output logic             empty
);
  wb_entry_t        mem_q [DEPTH];
  wb_entry_t        mem_d [DEPTH];
  logic [DEPTH-1:0] vld_q, vld_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             do_push, do_pop;
  assign full    = cnt_q == CW'(DEPTH);
  assign empty   = cnt_q == '0;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  // Clear before set: a simultaneous push never targets the head slot unless the FIFO was empty.
  always_comb begin
    mem_d = mem_q;
    vld_d = vld_q;
    if (do_pop) vld_d[rd_ptr_q] = 1'b0;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_entry;
      vld_d[wr_ptr_q] = 1'b1;
    end
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    cnt_d    = cnt_q + CW'(do_push) - CW'(do_pop);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '{default: '0};
      vld_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      vld_q    <= vld_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end
  assign mem    = mem_q;
  assign vld    = vld_q;
  assign rd_ptr = rd_ptr_q;
  assign cnt    = cnt_q;
endmodule

// File: rtl/rw_writeback_unit.sv
// rw_writeback_unit: SimpleRISC register-write stage, queues retiring writes for register-file port B
//   clk, rst_n      : clock, async active-low reset
//   bus             : retire input and port B req/gnt (master side)
//   byp_addr1/2     : OF read addresses; byp_hit1/2, byp_data1/2 : youngest queued match
//   pend_cnt        : queued writes; retire_cnt : instructions accepted since reset
module rw_writeback_unit #(
  parameter int DEPTH = 2,
  parameter logic [rw_writeback_unit_pkg::REG_W-1:0] RA_IDX = rw_writeback_unit_pkg::RA_IDX,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  rw_writeback_unit_if.master                      bus,
  input  logic [rw_writeback_unit_pkg::REG_W-1:0]  byp_addr1,
  input  logic [rw_writeback_unit_pkg::REG_W-1:0]  byp_addr2,
  output logic                                     byp_hit1,
  output logic                                     byp_hit2,
  output logic [rw_writeback_unit_pkg::XLEN-1:0]   byp_data1,
  output logic [rw_writeback_unit_pkg::XLEN-1:0]   byp_data2,
  output logic [CW-1:0]                            pend_cnt,
  output logic [rw_writeback_unit_pkg::XLEN-1:0]   retire_cnt
);
  import rw_writeback_unit_pkg::*;
  wb_entry_t        mem [DEPTH];
  wb_entry_t        sel;
  logic [DEPTH-1:0] vld;
  logic [AW-1:0]    rd_ptr;
  logic             full, empty, accept;
  logic [XLEN-1:0]  retire_cnt_q, retire_cnt_d;
  // Ready depends on registered occupancy only, so a grant never admits an enqueue when full.
  assign bus.in_ready = rst_n && !full;
  assign accept       = bus.in_valid && bus.in_ready;
  assign sel.port     = bus.in_isCall ? RA_IDX : bus.in_inst[RD_HI:RD_LO];
  assign sel.data     = bus.in_isCall ? bus.in_pc + 32'd4 : bus.in_isLd ? bus.in_ld : bus.in_alu;
  rw_writeback_unit_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (accept && bus.in_isWb),
    .push_entry (sel),
    .pop        (bus.wr_gnt),
    .mem        (mem),
    .vld        (vld),
    .rd_ptr     (rd_ptr),
    .cnt        (pend_cnt),
    .full       (full),
    .empty      (empty)
  );
  assign bus.wr_req  = !empty;
  assign bus.wr_port = mem[rd_ptr].port;
  assign bus.wr_data = mem[rd_ptr].data;
  always_comb retire_cnt_d = retire_cnt_q + XLEN'(accept);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) retire_cnt_q <= '0;
    else        retire_cnt_q <= retire_cnt_d;
  end
  assign retire_cnt = retire_cnt_q;
  // Walk entries oldest to youngest from the head so later matches override earlier ones.
  always_comb begin
    byp_hit1  = 1'b0;
    byp_hit2  = 1'b0;
    byp_data1 = '0;
    byp_data2 = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (vld[rd_ptr + AW'(k)] && mem[rd_ptr + AW'(k)].port == byp_addr1) begin
        byp_hit1  = 1'b1;
        byp_data1 = mem[rd_ptr + AW'(k)].data;
      end
      if (vld[rd_ptr + AW'(k)] && mem[rd_ptr + AW'(k)].port == byp_addr2) begin
        byp_hit2  = 1'b1;
        byp_data2 = mem[rd_ptr + AW'(k)].data;
      end
    end
  end
endmodule

// File: tb/tb_rw_writeback_unit.sv
// tb_rw_writeback_unit: directed and randomized checks of the writeback unit against a queue model
module tb_rw_writeback_unit;
  localparam int DEPTH = 2;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [4:0]  byp_addr1 = '0, byp_addr2 = '0;
  logic        byp_hit1, byp_hit2;
  logic [31:0] byp_data1, byp_data2, retire_cnt;
  logic [1:0]  pend_cnt;
  int          n_chk = 0, n_fail = 0;
  bit          run = 1'b0;
  logic [36:0] mq[$];
  logic [31:0] mret;
  logic [32:0] eb1, eb2;

  rw_writeback_unit_if bus();

  rw_writeback_unit #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus.master),
    .byp_addr1  (byp_addr1),
    .byp_addr2  (byp_addr2),
    .byp_hit1   (byp_hit1),
    .byp_hit2   (byp_hit2),
    .byp_data1  (byp_data1),
    .byp_data2  (byp_data2),
    .pend_cnt   (pend_cnt),
    .retire_cnt (retire_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Model: pending writes as a queue of {port, data}; ready judged on occupancy before the edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      mret = '0;
    end else begin
      bit pop, acc;
      pop = bus.wr_gnt && mq.size() != 0;
      acc = bus.in_valid && mq.size() < DEPTH;
      if (pop) void'(mq.pop_front());
      if (acc) begin
        mret = mret + 32'd1;
        if (bus.in_isWb)
          mq.push_back(bus.in_isCall ? {5'd31, bus.in_pc + 32'd4}
                                     : {bus.in_inst[25:21], bus.in_isLd ? bus.in_ld : bus.in_alu});
      end
    end
  end

  function automatic logic [32:0] byp_m(input logic [4:0] a);
    logic [32:0] r = '0;
    foreach (mq[i]) if (mq[i][36:32] == a) r = {1'b1, mq[i][31:0]};
    return r;
  endfunction

  always @(negedge clk) begin
    if (run) begin
      chk("in_ready", 32'(bus.in_ready), 32'(rst_n && mq.size() < DEPTH));
      chk("wr_req", 32'(bus.wr_req), 32'(mq.size() != 0));
      chk("pend_cnt", 32'(pend_cnt), 32'(mq.size()));
      chk("retire_cnt", retire_cnt, mret);
      if (mq.size() != 0) begin
        chk("wr_port", 32'(bus.wr_port), 32'(mq[0][36:32]));
        chk("wr_data", bus.wr_data, mq[0][31:0]);
      end
      eb1 = byp_m(byp_addr1);
      eb2 = byp_m(byp_addr2);
      chk("byp_hit1", 32'(byp_hit1), 32'(eb1[32]));
      chk("byp_hit2", 32'(byp_hit2), 32'(eb2[32]));
      if (eb1[32]) chk("byp_data1", byp_data1, eb1[31:0]);
      if (eb2[32]) chk("byp_data2", byp_data2, eb2[31:0]);
    end
  end

  task automatic put(input logic [4:0] rd, input logic [31:0] alu);
    bus.in_valid  = 1'b1;
    bus.in_isWb   = 1'b1;
    bus.in_isLd   = 1'b0;
    bus.in_isCall = 1'b0;
    bus.in_inst   = 32'(rd) << 21;
    bus.in_alu    = alu;
  endtask

  initial begin
    bus.in_valid = 0; bus.in_pc = 0; bus.in_inst = 0; bus.in_alu = 0; bus.in_ld = 0;
    bus.in_isWb = 0; bus.in_isLd = 0; bus.in_isCall = 0; bus.wr_gnt = 0;
    #1 rst_n = 1'b0;
    run = 1'b1;
    tick(); tick();
    chk("rst wr_req", 32'(bus.wr_req), 32'd0);
    chk("rst pend_cnt", 32'(pend_cnt), 32'd0);
    chk("rst in_ready", 32'(bus.in_ready), 32'd0);
    chk("rst retire_cnt", retire_cnt, 32'd0);
    chk("rst wr_port", 32'(bus.wr_port), 32'd0);
    chk("rst wr_data", bus.wr_data, 32'd0);
    chk("rst byp_hit1", 32'(byp_hit1), 32'd0);
    rst_n = 1'b1;
    #1 chk("ready after rst", 32'(bus.in_ready), 32'd1);
    // ALU write, grant held: no flow-through, one cycle in queue
    tick();
    bus.wr_gnt = 1'b1;
    put(5'd5, 32'h1234);
    #1 chk("no flow-through", 32'(bus.wr_req), 32'd0);
    tick();
    bus.in_valid = 1'b0;
    chk("alu wr_req", 32'(bus.wr_req), 32'd1);
    chk("alu wr_port", 32'(bus.wr_port), 32'd5);
    chk("alu wr_data", bus.wr_data, 32'h1234);
    tick();
    chk("alu drained", 32'(pend_cnt), 32'd0);
    // Calls: pc+4 to r31, wraps at 2^32, beats isLd
    bus.wr_gnt = 1'b0;
    put(5'd3, 32'h5555);
    bus.in_isCall = 1'b1; bus.in_isLd = 1'b1; bus.in_ld = 32'hDEAD; bus.in_pc = 32'h100;
    tick();
    chk("call wr_port", 32'(bus.wr_port), 32'd31);
    chk("call wr_data", bus.wr_data, 32'h104);
    bus.in_pc = 32'hFFFF_FFFC;
    bus.wr_gnt = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    chk("call wrap port", 32'(bus.wr_port), 32'd31);
    chk("call wrap data", bus.wr_data, 32'h0);
    chk("call wrap pend", 32'(pend_cnt), 32'd1);
    tick();
    chk("call drained", 32'(pend_cnt), 32'd0);
    // Back-pressure: third write stalls until a slot is free at the edge
    bus.wr_gnt = 1'b0;
    put(5'd1, 32'h11);
    tick(); put(5'd2, 32'h22);
    tick(); put(5'd3, 32'h33);
    tick();
    chk("full pend", 32'(pend_cnt), 32'd2);
    chk("full ready", 32'(bus.in_ready), 32'd0);
    chk("full head", 32'(bus.wr_port), 32'd1);
    tick(); tick();
    chk("stall pend", 32'(pend_cnt), 32'd2);
    chk("stall retire", retire_cnt, 32'd5);
    bus.wr_gnt = 1'b1;
    tick();
    chk("drain1 pend", 32'(pend_cnt), 32'd1);
    chk("drain1 port", 32'(bus.wr_port), 32'd2);
    tick();
    bus.in_valid = 1'b0;
    chk("drain2 pend", 32'(pend_cnt), 32'd1);
    chk("drain2 port", 32'(bus.wr_port), 32'd3);
    chk("drain2 data", bus.wr_data, 32'h33);
    tick();
    chk("drain3 pend", 32'(pend_cnt), 32'd0);
    chk("bp retire", retire_cnt, 32'd6);
    // Bypass: youngest of two r7 writes wins, survives head dequeue
    bus.wr_gnt = 1'b0;
    put(5'd7, 32'hA);
    tick(); put(5'd7, 32'hB);
    tick();
    bus.in_valid = 1'b0;
    byp_addr1 = 5'd7; byp_addr2 = 5'd8;
    #1;
    chk("byp2 hit1", 32'(byp_hit1), 32'd1);
    chk("byp2 data1", byp_data1, 32'hB);
    chk("byp2 hit2", 32'(byp_hit2), 32'd0);
    bus.wr_gnt = 1'b1;
    tick();
    chk("byp1 hit1", 32'(byp_hit1), 32'd1);
    chk("byp1 data1", byp_data1, 32'hB);
    chk("byp1 head", bus.wr_data, 32'hB);
    tick();
    chk("byp0 hit1", 32'(byp_hit1), 32'd0);
    // Non-writing instructions only bump the retire counter
    bus.wr_gnt = 1'b0;
    put(5'd9, 32'h99);
    bus.in_isWb = 1'b0;
    repeat (10) tick();
    bus.in_valid = 1'b0;
    chk("nowb retire", retire_cnt, 32'd18);
    chk("nowb pend", 32'(pend_cnt), 32'd0);
    // Reset mid-stream with two entries queued, grant during reset ignored
    put(5'd4, 32'h44);
    tick(); tick();
    bus.in_valid = 1'b0;
    chk("pre-rst pend", 32'(pend_cnt), 32'd2);
    bus.wr_gnt = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("mid-rst wr_req", 32'(bus.wr_req), 32'd0);
    chk("mid-rst pend", 32'(pend_cnt), 32'd0);
    chk("mid-rst ready", 32'(bus.in_ready), 32'd0);
    tick();
    chk("mid-rst retire", retire_cnt, 32'd0);
    chk("mid-rst ready2", 32'(bus.in_ready), 32'd0);
    rst_n = 1'b1;
    #1 chk("post-rst ready", 32'(bus.in_ready), 32'd1);
    // Random traffic on a small register set to exercise bypass priority
    for (int c = 0; c < 3000; c++) begin
      tick();
      bus.in_valid  = $urandom_range(0, 3) != 0;
      bus.in_isWb   = $urandom_range(0, 4) != 0;
      bus.in_isLd   = $urandom_range(0, 1) == 1;
      bus.in_isCall = $urandom_range(0, 5) == 0;
      bus.in_pc     = $urandom;
      bus.in_inst   = $urandom;
      bus.in_inst[25:21] = $urandom_range(0, 1) == 1 ? 5'($urandom_range(0, 3)) : 5'd31;
      bus.in_alu    = $urandom;
      bus.in_ld     = $urandom;
      bus.wr_gnt    = $urandom_range(0, 2) == 0;
      byp_addr1     = 5'($urandom_range(0, 3));
      byp_addr2     = $urandom_range(0, 3) == 0 ? 5'd31 : 5'($urandom_range(0, 3));
      if (c == 1500) rst_n = 1'b0;
      if (c == 1503) rst_n = 1'b1;
    end
    tick();
    run = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
